router_reg: RTL
===============

# router_reg

Datapath register stage of the 1x3 router. It sits directly downstream of the router FSM and upstream of the three output FIFOs. Its inputs are the FSM state strobes (detect_add, lfd_state, ld_state, laf_state, full_state, rst_in_reg) and the source byte stream. It latches the header, forwards header and payload bytes to the FIFO write bus, and parks one byte while the target FIFO is full. It also computes and checks packet parity, and returns parity_done and low_pkt_valid to the FSM.

## Interface
- DATA_WIDTH, 8, width of the byte bus; header[1:0] is the destination address and header[7:2] is the payload length.
- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- pkt_valid  in  1  source byte valid; falls on the parity byte.
- data_in  in  DATA_WIDTH  source byte.
- fifo_full  in  1  full flag of the currently addressed FIFO.
- detect_add, lfd_state, ld_state, laf_state, full_state, rst_in_reg  in  1 each  FSM state strobes; at most one is high in any cycle.
- dout  out  DATA_WIDTH  registered byte to the FIFO write bus.
- parity_done  out  1  the parity byte has been captured.
- low_pkt_valid  out  1  pkt_valid was seen low during a load.
- err  out  1  parity mismatch for the current packet.

## Operation
- Reset: dout, parity_done, low_pkt_valid and err are 0. The internal registers header_byte, hold_byte, int_parity and pkt_parity are also 0.
- Header capture: when detect_add & pkt_valid & data_in[1:0] != 2'b11, load header_byte <= data_in. Address 2'b11 is ignored and header_byte holds.
- dout update. The first matching rule wins:
  - lfd_state: dout <= header_byte.
  - ld_state & !fifo_full: dout <= data_in.
  - ld_state & fifo_full: hold_byte <= data_in; dout holds.
  - laf_state: dout <= hold_byte.
  - Otherwise dout holds.
- Internal parity:
  - detect_add: int_parity <= 0.
  - lfd_state: int_parity ^= header_byte.
  - ld_state & pkt_valid: int_parity ^= data_in, regardless of fifo_full, because the byte is captured either into dout or into hold_byte.
- Packet parity: on ld_state & !pkt_valid, load pkt_parity <= data_in.
- parity_done:
  - Set on ld_state & !pkt_valid.
  - Cleared on detect_add.
  - Set has priority over clear. The two cannot coincide, because the strobes are one-hot.
- low_pkt_valid:
  - Set on ld_state & !pkt_valid.
  - Cleared on rst_in_reg or detect_add.
- err: err <= parity_done & (int_parity != pkt_parity), evaluated every cycle. It falls the cycle after detect_add clears parity_done.
- full_state: no register update. dout, hold_byte and both parity registers hold.
- A parity byte that arrives while fifo_full is high goes to hold_byte. It is emitted in laf_state, and parity_done is already 1, so the FSM returns to DECODE_ADDRESS.

## Timing
- Every output is a flop, with one-cycle latency from strobe to output. Example: lfd_state high in cycle N gives dout = header in N+1.
- parity_done and low_pkt_valid rise one cycle after the ld_state & !pkt_valid cycle.
- err is valid two cycles after the parity byte is presented.
- Asserting reset mid-packet clears all state immediately, without waiting for a clock edge. The next packet then starts from detect_add.
- A simultaneous ld_state & fifo_full & !pkt_valid captures the byte into hold_byte and into pkt_parity, and sets both flags.
- Back-to-back packets: detect_add in the cycle after rst_in_reg fully re-arms the block.

## Structure
- Shared package router_pkg holds:
  - DATA_WIDTH default.
  - ADDR_LSB/ADDR_MSB and LEN_LSB/LEN_MSB header field positions.
  - ADDR_INVALID = 2'b11.
  - State encodings already shared with the FSM.
- One sub-module, router_parity: the accumulator, pkt_parity register and err compare. Its inputs are the clear, accumulate, capture enables and byte. It outputs err.
- router_reg keeps the header, hold and dout registers and the two flags.

## Test plan
- Clean packet:
  - Stimulus: header 8'h0D, payload 11/22/33, parity 8'h0D, fifo_full = 0 throughout.
  - Required: dout sequence 0D, 11, 22, 33, 0D; parity_done = 1 one cycle after the parity byte; err = 0.
- Bad parity:
  - Stimulus: same packet with parity byte 8'h0C.
  - Required: err = 1 two cycles after the parity byte; err returns to 0 one cycle after the next detect_add.
- Full mid-payload:
  - Stimulus: fifo_full = 1 while ld_state presents 8'h22, then full_state for 3 cycles, then laf_state.
  - Required: dout holds 8'h11 until laf_state, then becomes 8'h22; int_parity still matches, so err = 0.
- Parity byte during full:
  - Stimulus: ld_state & fifo_full & !pkt_valid with data 8'h0D.
  - Required: parity_done = 1 before laf_state; laf_state drives dout = 8'h0D.
- Invalid address:
  - Stimulus: detect_add & pkt_valid with data_in = 8'h0F.
  - Required: header_byte is unchanged, and the next lfd_state outputs the previous header.
- Asynchronous reset:
  - Stimulus: assert reset between clock edges in the middle of a payload.
  - Required: dout, parity_done, low_pkt_valid and err are all 0 immediately; the next clean packet passes with err = 0.

Source files
------------

// File: rtl/router_pkg.sv
// Shared definitions for the 1x3 router: byte width, header field layout,
// reserved address, and the FSM state encoding.
package router_pkg;

   localparam int unsigned DATA_WIDTH = 8;

   localparam int unsigned ADDR_LSB = 0;
   localparam int unsigned ADDR_MSB = 1;
   localparam int unsigned LEN_LSB  = 2;
   localparam int unsigned LEN_MSB  = 7;
   localparam int unsigned ADDR_W   = ADDR_MSB - ADDR_LSB + 1;
   localparam int unsigned LEN_W    = LEN_MSB - LEN_LSB + 1;

   localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

   typedef enum logic [2:0] {
      DECODE_ADDRESS     = 3'd0,
      LOAD_FIRST_DATA    = 3'd1,
      LOAD_DATA          = 3'd2,
      WAIT_TILL_EMPTY    = 3'd3,
      FIFO_FULL_STATE    = 3'd4,
      LOAD_AFTER_FULL    = 3'd5,
      LOAD_PARITY        = 3'd6,
      CHECK_PARITY_ERROR = 3'd7
   } fsm_state_e;

   function automatic logic [ADDR_W-1:0] hdr_addr(input logic [DATA_WIDTH-1:0] hdr);
      return hdr[ADDR_MSB:ADDR_LSB];
   endfunction

   function automatic logic [LEN_W-1:0] hdr_len(input logic [DATA_WIDTH-1:0] hdr);
      return hdr[LEN_MSB:LEN_LSB];
   endfunction

endpackage

// File: rtl/router_parity.sv
// Running XOR of header and payload bytes, captured packet parity byte, and
// the registered mismatch flag.
module router_parity
   import router_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = router_pkg::DATA_WIDTH
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  clear,
   input  logic                  acc_en,
   input  logic [DATA_WIDTH-1:0] acc_byte,
   input  logic                  cap_en,
   input  logic [DATA_WIDTH-1:0] cap_byte,
   input  logic                  parity_done,
   output logic                  err
);

   logic [DATA_WIDTH-1:0] int_parity;
   logic [DATA_WIDTH-1:0] pkt_parity;

   // err compares the previous-cycle registers, so it trails parity_done by one cycle
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         int_parity <= '0;
         pkt_parity <= '0;
         err        <= 1'b0;
      end else begin
         if (clear)
            int_parity <= '0;
         else if (acc_en)
            int_parity <= int_parity ^ acc_byte;
         if (cap_en)
            pkt_parity <= cap_byte;
         err <= parity_done & (int_parity != pkt_parity);
      end
   end

endmodule

// File: rtl/router_reg.sv
// Router datapath register stage: header latch, FIFO write byte, parked byte
// while the FIFO is full, and the parity/low-valid flags returned to the FSM.
module router_reg
   import router_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = router_pkg::DATA_WIDTH
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  pkt_valid,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  fifo_full,
   input  logic                  detect_add,
   input  logic                  lfd_state,
   input  logic                  ld_state,
   input  logic                  laf_state,
   input  logic                  full_state,
   input  logic                  rst_in_reg,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  parity_done,
   output logic                  low_pkt_valid,
   output logic                  err
);

   logic [DATA_WIDTH-1:0] header_byte;
   logic [DATA_WIDTH-1:0] hold_byte;

   logic                  load_c;
   logic                  last_c;
   logic                  hdr_ok_c;
   logic                  acc_en_c;
   logic [DATA_WIDTH-1:0] acc_byte_c;

   // full_state freezes the datapath; masking ld keeps that true even on overlap
   always_comb begin
      load_c     = ld_state & ~full_state;
      last_c     = load_c & ~pkt_valid;
      hdr_ok_c   = detect_add & pkt_valid & (hdr_addr(data_in) != ADDR_INVALID);
      acc_en_c   = lfd_state | (load_c & pkt_valid);
      acc_byte_c = lfd_state ? header_byte : data_in;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         header_byte <= '0;
         hold_byte   <= '0;
         dout        <= '0;
      end else begin
         if (hdr_ok_c)
            header_byte <= data_in;
         if (lfd_state)
            dout <= header_byte;
         else if (load_c && !fifo_full)
            dout <= data_in;
         else if (load_c && fifo_full)
            hold_byte <= data_in;
         else if (laf_state)
            dout <= hold_byte;
      end
   end

   // Set wins over clear for both flags
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         parity_done   <= 1'b0;
         low_pkt_valid <= 1'b0;
      end else begin
         if (last_c)
            parity_done <= 1'b1;
         else if (detect_add)
            parity_done <= 1'b0;
         if (last_c)
            low_pkt_valid <= 1'b1;
         else if (rst_in_reg || detect_add)
            low_pkt_valid <= 1'b0;
      end
   end

   router_parity #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_parity (
      .clock       (clock),
      .reset       (reset),
      .clear       (detect_add),
      .acc_en      (acc_en_c),
      .acc_byte    (acc_byte_c),
      .cap_en      (last_c),
      .cap_byte    (data_in),
      .parity_done (parity_done),
      .err         (err)
   );

endmodule
